// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver (parity none/even/odd, 1/2 stop bits) with a valid/ready output.
// Define UART_RX_BREAK_DET_EN to add the break_det output and the BREAK_WAIT state.
module uart_rx_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [1:0]            parity_mode,
    input  logic                  stop_bits,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  frame_error,
    output logic                  parity_error,
`ifdef UART_RX_BREAK_DET_EN
    output logic                  break_det,
`endif
    output logic                  overrun_error
);
    localparam int TW = PRESCALE_W + 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK_WAIT
    } state_t;

    state_t                r_state, w_state;
    logic                  r_sync1, r_sync2, r_rxd_s;
    logic [TW-1:0]         r_timer, w_timer;
    logic [TW-1:0]         r_period, w_period;
    logic [3:0]            r_bitcnt, w_bitcnt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift;
    logic                  r_par_bit, w_par_bit;
    logic [1:0]            r_pmode, w_pmode;
    logic                  r_stop2, w_stop2;
    logic                  r_second, w_second;
    logic [DATA_WIDTH-1:0] r_tdata, w_tdata;
    logic                  r_tvalid, w_tvalid;
    logic                  r_ferr, w_ferr;
    logic                  r_perr, w_perr;
    logic                  r_oerr, w_oerr;
`ifdef UART_RX_BREAK_DET_EN
    logic                  r_brk, w_brk;
`endif
    logic [PRESCALE_W-1:0] w_p;
    logic                  w_expire;
    logic                  w_par_en;
    logic                  w_par_exp;

    assign w_p       = (prescale == '0) ? PRESCALE_W'(1) : prescale;
    assign w_expire  = (r_timer == '0);
    assign w_par_en  = (r_pmode == 2'b01) || (r_pmode == 2'b10);
    assign w_par_exp = (r_pmode == 2'b10) ? ~^r_shift : ^r_shift;

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign busy          = (r_state != S_IDLE);
    assign frame_error   = r_ferr;
    assign parity_error  = r_perr;
    assign overrun_error = r_oerr;
`ifdef UART_RX_BREAK_DET_EN
    assign break_det     = r_brk;
`endif

    // Two-flop synchroniser plus one stage; the FSM only ever looks at r_rxd_s
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rxd_s <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_rxd_s <= r_sync2;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_period  <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_pmode   <= 2'b00;
            r_stop2   <= 1'b0;
            r_second  <= 1'b0;
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_ferr    <= 1'b0;
            r_perr    <= 1'b0;
            r_oerr    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            r_brk     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state;
            r_timer   <= w_timer;
            r_period  <= w_period;
            r_bitcnt  <= w_bitcnt;
            r_shift   <= w_shift;
            r_par_bit <= w_par_bit;
            r_pmode   <= w_pmode;
            r_stop2   <= w_stop2;
            r_second  <= w_second;
            r_tdata   <= w_tdata;
            r_tvalid  <= w_tvalid;
            r_ferr    <= w_ferr;
            r_perr    <= w_perr;
            r_oerr    <= w_oerr;
`ifdef UART_RX_BREAK_DET_EN
            r_brk     <= w_brk;
`endif
        end
    end

    // Next-state logic: each state waits for timer expiry, then samples r_rxd_s and reloads one bit period
    always_comb begin
        w_state   = r_state;
        w_timer   = w_expire ? r_timer : r_timer - TW'(1);
        w_period  = r_period;
        w_bitcnt  = r_bitcnt;
        w_shift   = r_shift;
        w_par_bit = r_par_bit;
        w_pmode   = r_pmode;
        w_stop2   = r_stop2;
        w_second  = r_second;
        w_tdata   = r_tdata;
        w_tvalid  = r_tvalid && !m_axis_tready;
        w_ferr    = 1'b0;
        w_perr    = 1'b0;
        w_oerr    = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        w_brk     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_rxd_s) begin
                    w_pmode  = parity_mode;
                    w_stop2  = stop_bits;
                    w_period = {w_p, 3'b000} - TW'(1);
                    w_timer  = {1'b0, w_p, 2'b00} - TW'(1);
                    w_state  = S_START;
                end
            end
            S_START: begin
                if (w_expire) begin
                    w_timer  = r_period;
                    w_bitcnt = '0;
                    w_state  = r_rxd_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_expire) begin
                    w_shift  = {r_rxd_s, r_shift[DATA_WIDTH-1:1]};
                    w_bitcnt = r_bitcnt + 4'd1;
                    w_timer  = r_period;
                    w_second = 1'b0;
                    if (r_bitcnt == 4'(DATA_WIDTH - 1))
                        w_state = w_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_expire) begin
                    w_par_bit = r_rxd_s;
                    w_timer   = r_period;
                    w_state   = S_STOP;
                end
            end
            S_STOP: begin
                if (w_expire) begin
                    if (!r_rxd_s) begin
`ifdef UART_RX_BREAK_DET_EN
                        if (!r_second && r_shift == '0 && !(w_par_en && r_par_bit)) begin
                            w_brk   = 1'b1;
                            w_state = S_BREAK_WAIT;
                        end else begin
                            w_ferr  = 1'b1;
                            w_state = S_IDLE;
                        end
`else
                        w_ferr  = 1'b1;
                        w_state = S_IDLE;
`endif
                    end else if (r_stop2 && !r_second) begin
                        w_second = 1'b1;
                        w_timer  = r_period;
                    end else begin
                        w_state = S_IDLE;
                        if (w_par_en && (r_par_bit != w_par_exp)) begin
                            w_perr = 1'b1;
                        end else if (!r_tvalid || m_axis_tready) begin
                            w_tdata  = r_shift;
                            w_tvalid = 1'b1;
                        end else begin
                            w_oerr = 1'b1;
                        end
                    end
                end
            end
            S_BREAK_WAIT: begin
                if (r_rxd_s)
                    w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench; stimulus pushes expected events, a forked monitor pops and compares them.
module tb_uart_rx_cfg;
    localparam int EV_DATA = 0;
    localparam int EV_FRAME = 1;
    localparam int EV_PAR = 2;
    localparam int EV_OVR = 3;
    localparam int EV_BRK = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [15:0] prescale = 16'd4;
    logic [1:0]  parity_mode = 2'b00;
    logic        stop_bits = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        busy;
    logic        frame_error;
    logic        parity_error;
    logic        overrun_error;
`ifdef UART_RX_BREAK_DET_EN
    logic        break_det;
`endif

    int          n_pass = 0;
    int          n_total = 0;
    int          exp_kind[$];
    logic [7:0]  exp_data[$];

    uart_rx_cfg #(.DATA_WIDTH(8), .PRESCALE_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .rxd           (rxd),
        .prescale      (prescale),
        .parity_mode   (parity_mode),
        .stop_bits     (stop_bits),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .frame_error   (frame_error),
        .parity_error  (parity_error),
`ifdef UART_RX_BREAK_DET_EN
        .break_det     (break_det),
`endif
        .overrun_error (overrun_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] data);
        exp_kind.push_back(kind);
        exp_data.push_back(data);
    endtask

    task automatic got_ev(input int kind, input logic [7:0] data);
        int         k;
        logic [7:0] d;
        n_total++;
        if (exp_kind.size() == 0) begin
            $display("FAIL unexpected_event: got kind %0d data %h expected none", kind, data);
        end else begin
            k = exp_kind.pop_front();
            d = exp_data.pop_front();
            if (k == kind && (kind != EV_DATA || d == data)) n_pass++;
            else $display("FAIL event: got kind %0d data %h expected kind %0d data %h", kind, data, k, d);
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (32) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par, input logic pbit,
                              input logic s1, input bit two, input logic s2);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (par) send_bit(pbit);
        send_bit(s1);
        if (two) send_bit(s2);
        rxd = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (frame_error) got_ev(EV_FRAME, 8'h00);
                    if (parity_error) got_ev(EV_PAR, 8'h00);
                    if (overrun_error) got_ev(EV_OVR, 8'h00);
`ifdef UART_RX_BREAK_DET_EN
                    if (break_det) got_ev(EV_BRK, 8'h00);
`endif
                    if (m_axis_tvalid && m_axis_tready) got_ev(EV_DATA, m_axis_tdata);
                end
            end
        join_none

        repeat (5) @(negedge clk);
        chk("reset_tvalid", 32'(m_axis_tvalid), 0);
        chk("reset_tdata", 32'(m_axis_tdata), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_errors", 32'({frame_error, parity_error, overrun_error}), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 8N1 0xA5
        expect_ev(EV_DATA, 8'hA5);
        send_frame(8'hA5, 0, 1'b0, 1'b1, 0, 1'b1);
        chk("busy_after_8n1", 32'(busy), 0);
        chk("tvalid_dropped_8n1", 32'(m_axis_tvalid), 0);

        // 8E1 0x03: bad parity then good parity
        parity_mode = 2'b01;
        expect_ev(EV_PAR, 8'h00);
        send_frame(8'h03, 1, 1'b1, 1'b1, 0, 1'b1);
        expect_ev(EV_DATA, 8'h03);
        send_frame(8'h03, 1, 1'b0, 1'b1, 0, 1'b1);

        // Start glitch of 10 clocks
        parity_mode = 2'b00;
        rxd = 1'b0;
        repeat (8) @(negedge clk);
        chk("busy_in_glitch", 32'(busy), 1);
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        chk("busy_after_glitch", 32'(busy), 0);

        // Bad single stop bit
        expect_ev(EV_FRAME, 8'h00);
        send_frame(8'h3C, 0, 1'b0, 1'b0, 0, 1'b1);
        repeat (40) @(negedge clk);

        // Overrun: tready low for two frames
        m_axis_tready = 1'b0;
        send_frame(8'h11, 0, 1'b0, 1'b1, 0, 1'b1);
        expect_ev(EV_OVR, 8'h00);
        send_frame(8'h22, 0, 1'b0, 1'b1, 0, 1'b1);
        chk("held_tvalid", 32'(m_axis_tvalid), 1);
        chk("held_tdata", 32'(m_axis_tdata), 32'h11);
        expect_ev(EV_DATA, 8'h11);
        m_axis_tready = 1'b1;
        repeat (2) @(negedge clk);
        chk("tvalid_after_accept", 32'(m_axis_tvalid), 0);

        // 8O2 0x55: odd parity bit is 1; second stop bad, then good
        parity_mode = 2'b10;
        stop_bits = 1'b1;
        expect_ev(EV_FRAME, 8'h00);
        send_frame(8'h55, 1, 1'b1, 1'b1, 1, 1'b0);
        repeat (40) @(negedge clk);
        expect_ev(EV_DATA, 8'h55);
        send_frame(8'h55, 1, 1'b1, 1'b1, 1, 1'b1);
        chk("busy_after_8o2", 32'(busy), 0);

        // Line held low about two frame times (8N1)
        parity_mode = 2'b00;
        stop_bits = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        expect_ev(EV_BRK, 8'h00);
`else
        expect_ev(EV_FRAME, 8'h00);
        expect_ev(EV_FRAME, 8'h00);
`endif
        rxd = 1'b0;
        repeat (600) @(negedge clk);
        chk("busy_in_break", 32'(busy), 1);
        repeat (18) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        chk("busy_after_break", 32'(busy), 0);
        chk("no_tvalid_after_break", 32'(m_axis_tvalid), 0);

        for (int i = 0; i < 200 && exp_kind.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_kind.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
